lbp_histogram: RTL and testbench
================================

// Module: lbp_histogram
// PURPOSE
//  Downstream stage of the LBP engine: consumes the lbp_valid/lbp_addr/lbp_data write stream and
//  accumulates a 256-bin histogram of LBP codes over interior pixels of the 128x128 frame.
//  On lbp_finish it drains its pipeline and streams all bins out over a valid/ready port to the
//  feature/classifier stage. Bin storage is an internal 256 x CNT_W register array.
// PARAMETERS
//  CODE_W   8   LBP code width; bins = 2**CODE_W
//  CNT_W    14  bin counter width; saturating (126*126 = 15876 fits)
//  ROW_W    7   row field width of lbp_addr = {row,col}
//  COL_W    7   col field width of lbp_addr
// PORTS
//  clk         in   1      clock
//  reset       in   1      asynchronous, active-high reset
//  lbp_valid   in   1      one LBP result this cycle
//  lbp_addr    in   14     {row,col} of the result
//  lbp_data    in   8      LBP code = bin index
//  lbp_finish  in   1      LBP engine done (level)
//  init_done   out  1      clear complete; LBP engine may be started
//  hist_valid  out  1      hist_bin/hist_count valid
//  hist_ready  in   1      consumer accepts current bin
//  hist_bin    out  8      bin index being output
//  hist_count  out  14     count of that bin
//  drop_err    out  1      sticky: input arrived outside ACCUM, or a bin saturated
//  done        out  1      all 256 bins accepted
// BEHAVIOUR
//  Reset: state=CLEAR, clr_idx=0, all outputs 0, pipeline regs invalid. Reset mid-operation aborts
//   any state; histogram is re-cleared from bin 0.
//  FSM: CLEAR -> ACCUM -> DRAIN -> DUMP -> DONE.
//   CLEAR: writes bin[clr_idx]=0, clr_idx++ per cycle; 256 cycles; on clr_idx==255 -> ACCUM.
//   ACCUM: init_done=1. Accepts lbp_valid every cycle, no backpressure. On lbp_finish -> DRAIN.
//   DRAIN: 2 cycles, lets in-flight increments commit; then -> DUMP (dump_idx=0).
//   DUMP: hist_valid=1, hist_bin=dump_idx, hist_count=bin[dump_idx]. Advance on
//    hist_valid&&hist_ready; data held stable while hist_ready=0. Accept of bin 255 -> DONE.
//   DONE: hist_valid=0, done=1, init_done=1; held until reset.
//  Accumulate pipeline (2 stages):
//   S1: register {v1,code1} = {lbp_valid && interior, lbp_data}. Interior: row,col both in
//    [1,126]; border addresses are ignored silently (no error).
//   S2: if v1: bin[code1] <= rd + 1, where rd = (v2 && code2==code1) ? wr_val2 : bin[code1]
//    (forwarding for back-to-back equal codes). Incoming increment counts exactly once.
//   Saturation: count 2**CNT_W-1 stays; sets drop_err.
//  lbp_valid while state != ACCUM: sample dropped, drop_err set. lbp_valid and lbp_finish in the
//   same cycle: sample counted (enters S1), then DRAIN.
//  Latency: sample at edge N is visible in bin array after edge N+2; DRAIN covers this.
//  hist_count width = CNT_W; sum of all bins = number of interior samples received.
// STRUCTURE
//  Shared package lbp_pkg: IMG_DIM=128, BORDER=1, CODE_W, CNT_W, ADDR_W=14, state enum
//   {CLEAR,ACCUM,DRAIN,DUMP,DONE}; shared with the LBP engine.
//  Sub-module: lbp_hist_bank (256 x CNT_W array, 1 comb read port, 1 sync write port, clear mux).
//  FSM, interior filter, forwarding and dump logic stay in the top.
// TESTING
//  1 Reset, idle 300 cycles -> init_done rises at cycle 256; lbp_finish, hist_ready=1 ->
//    256 beats, all hist_count=0, then done=1.
//  2 Send code 0x5A at {1,1}, 0x5A at {1,2}, 0x00 at {2,1} back-to-back, finish -> bin 0x5A=2,
//    bin 0x00=1, others 0 (exercises forwarding).
//  3 Samples at row 0, col 0, row 127, col 127 -> no count, drop_err=0.
//  4 Full frame of 15876 interior samples from LBP engine model -> bin sum 15876, each bin matches
//    golden reference.
//  5 During DUMP toggle hist_ready 1/0 randomly -> no bin skipped/duplicated, data stable while
//    stalled.
//  6 lbp_valid during CLEAR -> drop_err=1, no count; reset asserted mid-DUMP -> CLEAR restarts,
//    subsequent dump all zeros.

Source files
------------

// File: rtl/lbp_pkg.sv
// Shared LBP definitions: frame geometry, field widths and the histogram FSM states.
package lbp_pkg;

    localparam int unsigned IMG_DIM  = 128;
    localparam int unsigned BORDER   = 1;
    localparam int unsigned CODE_W   = 8;
    localparam int unsigned CNT_W    = 14;
    localparam int unsigned ROW_W    = 7;
    localparam int unsigned COL_W    = 7;
    localparam int unsigned ADDR_W   = ROW_W + COL_W;
    localparam int unsigned NUM_BINS = 1 << CODE_W;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ROW_W-1:0] ROW_MIN = ROW_W'(BORDER);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_DIM - 1 - BORDER);
    localparam logic [COL_W-1:0] COL_MIN = COL_W'(BORDER);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_DIM - 1 - BORDER);

    typedef enum logic [2:0] {
        StClear,
        StAccum,
        StDrain,
        StDump,
        StDone
    } state_e;

    // True when {row,col} lies off the one-pixel frame border.
    function automatic logic is_interior(input logic [ADDR_W-1:0] addr);
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        row = addr[ADDR_W-1:COL_W];
        col = addr[COL_W-1:0];
        return (row >= ROW_MIN) && (row <= ROW_MAX) && (col >= COL_MIN) && (col <= COL_MAX);
    endfunction

endpackage

// File: rtl/lbp_histogram_if.sv
// LBP result stream in, histogram bin stream out, plus status flags.
interface lbp_histogram_if;
    import lbp_pkg::*;

    logic              lbp_valid;
    logic [ADDR_W-1:0] lbp_addr;
    logic [CODE_W-1:0] lbp_data;
    logic              lbp_finish;
    logic              init_done;
    logic              hist_valid;
    logic              hist_ready;
    logic [CODE_W-1:0] hist_bin;
    logic [CNT_W-1:0]  hist_count;
    logic              drop_err;
    logic              done;

    // Producer / consumer side (LBP engine and classifier)
    modport master (
        output lbp_valid, lbp_addr, lbp_data, lbp_finish, hist_ready,
        input  init_done, hist_valid, hist_bin, hist_count, drop_err, done
    );

    // Histogram block side
    modport slave (
        input  lbp_valid, lbp_addr, lbp_data, lbp_finish, hist_ready,
        output init_done, hist_valid, hist_bin, hist_count, drop_err, done
    );

endinterface

// File: rtl/lbp_hist_bank.sv
// Bin storage: 2**CodeW counters, one combinational read port, one synchronous write port.
module lbp_hist_bank #(
    parameter int unsigned CodeW = 8,
    parameter int unsigned CntW  = 14
) (
    input  logic             clk,
    input  logic             clr_en,
    input  logic [CodeW-1:0] clr_addr,
    input  logic             we,
    input  logic [CodeW-1:0] wr_addr,
    input  logic [CntW-1:0]  wr_data,
    input  logic [CodeW-1:0] rd_addr,
    output logic [CntW-1:0]  rd_data
);

    localparam int unsigned Depth = 1 << CodeW;

    logic [CntW-1:0] mem_q [Depth];

    // Clear wins over increment; the controller never raises both in one cycle.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem_q[clr_addr] <= '0;
        end else if (we) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/lbp_histogram.sv
// LBP code histogram: clear, accumulate interior samples, drain the pipeline, stream bins out.
module lbp_histogram
    import lbp_pkg::*;
(
    input logic          clk,
    input logic          reset,
    lbp_histogram_if.slave bus
);

    state_e            state_q, state_d;
    logic [CODE_W-1:0] clr_idx_q, clr_idx_d;
    logic [CODE_W-1:0] dump_idx_q, dump_idx_d;
    logic              drain_cnt_q, drain_cnt_d;
    logic              v1_q, v1_d;
    logic [CODE_W-1:0] code1_q, code1_d;
    logic              v2_q, v2_d;
    logic [CODE_W-1:0] code2_q, code2_d;
    logic [CNT_W-1:0]  wr_val2_q, wr_val2_d;
    logic              drop_err_q, drop_err_d;
    logic              init_done_q, init_done_d;
    logic              hist_valid_q, hist_valid_d;
    logic              done_q, done_d;

    logic [CODE_W-1:0] rd_addr;
    logic [CNT_W-1:0]  rd_data;
    logic [CNT_W-1:0]  rd_val;
    logic              accept;

    assign accept  = hist_valid_q && bus.hist_ready;
    // The single read port serves the increment path except while bins are streamed out.
    assign rd_addr = (state_q == StDump) ? dump_idx_q : code1_q;
    // The S2 write of the previous sample lands at the same edge, so bypass the stale array value.
    assign rd_val  = (v2_q && (code2_q == code1_q)) ? wr_val2_q : rd_data;

    lbp_hist_bank #(
        .CodeW (CODE_W),
        .CntW  (CNT_W)
    ) u_bank (
        .clk      (clk),
        .clr_en   (state_q == StClear),
        .clr_addr (clr_idx_q),
        .we       (v2_q),
        .wr_addr  (code2_q),
        .wr_data  (wr_val2_q),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    // Increment pipeline: filter and capture, then read-modify-write with saturation.
    always_comb begin
        v1_d       = bus.lbp_valid && (state_q == StAccum) && is_interior(bus.lbp_addr);
        code1_d    = bus.lbp_data;
        v2_d       = v1_q;
        code2_d    = code1_q;
        wr_val2_d  = wr_val2_q;
        drop_err_d = drop_err_q;
        if (v1_q) begin
            wr_val2_d = (rd_val == CNT_MAX) ? CNT_MAX : rd_val + 1'b1;
        end
        if (bus.lbp_valid && (state_q != StAccum)) begin
            drop_err_d = 1'b1;
        end
        if (v1_q && (rd_val == CNT_MAX)) begin
            drop_err_d = 1'b1;
        end
    end

    // Sequencing CLEAR -> ACCUM -> DRAIN -> DUMP -> DONE and registered status outputs.
    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        dump_idx_d  = dump_idx_q;
        drain_cnt_d = drain_cnt_q;
        unique case (state_q)
            StClear: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == '1) begin
                    state_d = StAccum;
                end
            end
            StAccum: begin
                if (bus.lbp_finish) begin
                    state_d     = StDrain;
                    drain_cnt_d = 1'b0;
                end
            end
            StDrain: begin
                drain_cnt_d = 1'b1;
                if (drain_cnt_q) begin
                    state_d    = StDump;
                    dump_idx_d = '0;
                end
            end
            StDump: begin
                if (accept) begin
                    dump_idx_d = dump_idx_q + 1'b1;
                    if (dump_idx_q == '1) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StClear;
            end
        endcase
        init_done_d  = (state_d != StClear);
        hist_valid_d = (state_d == StDump);
        done_d       = (state_d == StDone);
    end

    // All control and pipeline state; reset restarts the clear sweep from bin 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StClear;
            clr_idx_q    <= '0;
            dump_idx_q   <= '0;
            drain_cnt_q  <= 1'b0;
            v1_q         <= 1'b0;
            code1_q      <= '0;
            v2_q         <= 1'b0;
            code2_q      <= '0;
            wr_val2_q    <= '0;
            drop_err_q   <= 1'b0;
            init_done_q  <= 1'b0;
            hist_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            dump_idx_q   <= dump_idx_d;
            drain_cnt_q  <= drain_cnt_d;
            v1_q         <= v1_d;
            code1_q      <= code1_d;
            v2_q         <= v2_d;
            code2_q      <= code2_d;
            wr_val2_q    <= wr_val2_d;
            drop_err_q   <= drop_err_d;
            init_done_q  <= init_done_d;
            hist_valid_q <= hist_valid_d;
            done_q       <= done_d;
        end
    end

    assign bus.init_done  = init_done_q;
    assign bus.hist_valid = hist_valid_q;
    assign bus.hist_bin   = dump_idx_q;
    assign bus.hist_count = hist_valid_q ? rd_data : '0;
    assign bus.drop_err   = drop_err_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_lbp_histogram.sv
// Bench for lbp_histogram: random LBP streams against a bin-count reference model.
module tb_lbp_histogram;

    logic clk = 1'b0;
    logic reset;

    lbp_histogram_if bus ();

    lbp_histogram u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int ref_bins [256];
    bit exp_drop;

    function automatic bit interior_ref(input int row, input int col);
        return (row >= 1) && (row <= 126) && (col >= 1) && (col <= 126);
    endfunction

    task automatic model_clear();
        foreach (ref_bins[i]) ref_bins[i] = 0;
        exp_drop = 1'b0;
    endtask

    task automatic model_add(input int row, input int col, input int code);
        if (interior_ref(row, col)) begin
            if (ref_bins[code] < 16383) ref_bins[code]++;
            else exp_drop = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.lbp_valid = 1'b0;
        bus.lbp_finish = 1'b0;
        bus.hist_ready = 1'b0;
        idle(2);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic wait_init(output int cycles);
        cycles = 0;
        while (!bus.init_done && cycles < 400) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        n_cmp++;
        if (bus.init_done !== 1'b1) begin
            n_err++;
            $display("FAIL init_timeout: init_done=%b after %0d cycles, want 1", bus.init_done, cycles);
        end
    endtask

    // One sample per call; consecutive calls give back-to-back samples.
    task automatic drive_sample(input int row, input int col, input int code, input bit fin,
                                input bit counted);
        bus.lbp_valid  = 1'b1;
        bus.lbp_addr   = {7'(row), 7'(col)};
        bus.lbp_data   = 8'(code);
        bus.lbp_finish = fin;
        @(posedge clk);
        #1;
        bus.lbp_valid = 1'b0;
        if (counted) model_add(row, col, code);
    endtask

    // Raise finish, then take bins in order until stop_after beats (or all 256 when negative).
    task automatic run_dump(input bit rand_ready, input int stop_after, input string tag);
        int idx = 0;
        int budget = 0;
        int sum = 0;
        int ref_sum = 0;
        int target;
        bit pend = 1'b0;
        bit prev_valid = 1'b0;
        bit was_stall;
        bit r;
        logic [7:0]  held_bin = '0;
        logic [13:0] held_cnt = '0;
        target = (stop_after < 0) ? 256 : stop_after;
        foreach (ref_bins[i]) ref_sum += ref_bins[i];
        bus.lbp_finish = 1'b1;
        while (idx < target && budget < 4000) begin
            @(posedge clk);
            #1;
            budget++;
            was_stall = 1'b0;
            if (pend) begin
                sum += int'(held_cnt);
                idx++;
                pend = 1'b0;
            end else if (prev_valid) begin
                was_stall = 1'b1;
            end
            if (idx >= target) break;
            prev_valid = bus.hist_valid;
            if (bus.hist_valid) begin
                if (was_stall) begin
                    n_cmp++;
                    if ({bus.hist_bin, bus.hist_count} !== {held_bin, held_cnt}) begin
                        n_err++;
                        $display("FAIL %s stall_hold: got bin %0d count %0d, want bin %0d count %0d",
                                 tag, bus.hist_bin, bus.hist_count, held_bin, held_cnt);
                    end
                end
                n_cmp++;
                if (bus.hist_bin !== 8'(idx)) begin
                    n_err++;
                    $display("FAIL %s bin_order: got %0d want %0d", tag, bus.hist_bin, idx);
                end
                n_cmp++;
                if (bus.hist_count !== 14'(ref_bins[idx])) begin
                    n_err++;
                    $display("FAIL %s count bin %0d: got %0d want %0d", tag, idx, bus.hist_count,
                             ref_bins[idx]);
                end
                held_bin = bus.hist_bin;
                held_cnt = bus.hist_count;
                r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.hist_ready = r;
                pend = r;
            end
        end
        bus.hist_ready = 1'b0;
        bus.lbp_finish = 1'b0;
        n_cmp++;
        if (idx < target) begin
            n_err++;
            $display("FAIL %s dump_timeout: got %0d beats want %0d", tag, idx, target);
        end
        if (stop_after < 0) begin
            n_cmp++;
            if ({bus.done, bus.hist_valid} !== 2'b10) begin
                n_err++;
                $display("FAIL %s done_state: got done=%b hist_valid=%b want 1/0", tag, bus.done,
                         bus.hist_valid);
            end
            n_cmp++;
            if (sum != ref_sum) begin
                n_err++;
                $display("FAIL %s bin_sum: got %0d want %0d", tag, sum, ref_sum);
            end
            n_cmp++;
            if (bus.drop_err !== exp_drop) begin
                n_err++;
                $display("FAIL %s drop_err: got %b want %b", tag, bus.drop_err, exp_drop);
            end
        end
    endtask

    task automatic test_reset();
        int cyc;
        reset = 1'b1;
        bus.lbp_valid = 1'b0;
        bus.lbp_addr = '0;
        bus.lbp_data = '0;
        bus.lbp_finish = 1'b0;
        bus.hist_ready = 1'b0;
        model_clear();
        #1;
        n_cmp++;
        if ({bus.init_done, bus.hist_valid, bus.done, bus.drop_err, bus.hist_bin, bus.hist_count}
            !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got init=%b hv=%b done=%b drop=%b bin=%0d cnt=%0d want 0",
                     bus.init_done, bus.hist_valid, bus.done, bus.drop_err, bus.hist_bin,
                     bus.hist_count);
        end
        idle(3);
        reset = 1'b0;
        wait_init(cyc);
        n_cmp++;
        if (cyc != 256) begin
            n_err++;
            $display("FAIL init_latency: got %0d cycles want 256", cyc);
        end
        idle(300 - cyc);
        run_dump(1'b0, -1, "idle_zero");
    endtask

    task automatic test_forwarding();
        int cyc;
        apply_reset();
        wait_init(cyc);
        drive_sample(1, 1, 8'h5A, 1'b0, 1'b1);
        drive_sample(1, 2, 8'h5A, 1'b0, 1'b1);
        drive_sample(2, 1, 8'h00, 1'b0, 1'b1);
        run_dump(1'b0, -1, "forwarding");
    endtask

    task automatic test_border();
        int cyc;
        apply_reset();
        wait_init(cyc);
        drive_sample(0, 5, $urandom_range(0, 255), 1'b0, 1'b1);
        drive_sample(5, 0, $urandom_range(0, 255), 1'b0, 1'b1);
        drive_sample(127, 5, $urandom_range(0, 255), 1'b0, 1'b1);
        drive_sample(5, 127, $urandom_range(0, 255), 1'b0, 1'b1);
        drive_sample(0, 0, $urandom_range(0, 255), 1'b0, 1'b1);
        drive_sample(127, 127, $urandom_range(0, 255), 1'b0, 1'b1);
        run_dump(1'b0, -1, "border");
    endtask

    // Last sample arrives together with finish and must still be counted.
    task automatic test_full_frame();
        int cyc;
        apply_reset();
        wait_init(cyc);
        for (int r = 1; r <= 126; r++) begin
            for (int c = 1; c <= 126; c++) begin
                drive_sample(r, c, $urandom_range(0, 255), (r == 126) && (c == 126), 1'b1);
                if ($urandom_range(0, 15) == 0 && !((r == 126) && (c == 126))) idle(1);
            end
        end
        run_dump(1'b0, -1, "full_frame");
    endtask

    task automatic test_stall();
        int cyc;
        int code;
        apply_reset();
        wait_init(cyc);
        for (int i = 0; i < 600; i++) begin
            code = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, 255);
            drive_sample($urandom_range(0, 127), $urandom_range(0, 127), code, 1'b0, 1'b1);
        end
        run_dump(1'b1, -1, "stall");
    endtask

    task automatic test_saturation();
        int cyc;
        apply_reset();
        wait_init(cyc);
        for (int i = 0; i < 16383; i++) drive_sample(5, 5, 8'h33, 1'b0, 1'b1);
        idle(3);
        n_cmp++;
        if (bus.drop_err !== 1'b0) begin
            n_err++;
            $display("FAIL sat_at_max: drop_err got %b want 0", bus.drop_err);
        end
        drive_sample(6, 6, 8'h33, 1'b0, 1'b1);
        drive_sample(7, 7, 8'h33, 1'b0, 1'b1);
        idle(3);
        n_cmp++;
        if (bus.drop_err !== 1'b1) begin
            n_err++;
            $display("FAIL sat_overflow: drop_err got %b want 1", bus.drop_err);
        end
        run_dump(1'b1, -1, "saturation");
    endtask

    task automatic test_clear_drop_and_reset();
        int cyc;
        apply_reset();
        for (int i = 0; i < 4; i++) drive_sample(10 + i, 10, 8'h11, 1'b0, 1'b0);
        exp_drop = 1'b1;
        wait_init(cyc);
        n_cmp++;
        if (bus.drop_err !== 1'b1) begin
            n_err++;
            $display("FAIL clear_drop: drop_err got %b want 1", bus.drop_err);
        end
        run_dump(1'b0, -1, "clear_drop");

        apply_reset();
        wait_init(cyc);
        n_cmp++;
        if (bus.drop_err !== 1'b0) begin
            n_err++;
            $display("FAIL drop_cleared: drop_err got %b want 0", bus.drop_err);
        end
        for (int i = 0; i < 80; i++) begin
            drive_sample($urandom_range(1, 126), $urandom_range(1, 126), $urandom_range(0, 255),
                         1'b0, 1'b1);
        end
        run_dump(1'b1, 100, "pre_abort");
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.hist_valid, bus.init_done, bus.done} !== 3'b000) begin
            n_err++;
            $display("FAIL abort_outputs: got hv=%b init=%b done=%b want 000", bus.hist_valid,
                     bus.init_done, bus.done);
        end
        idle(2);
        reset = 1'b0;
        model_clear();
        wait_init(cyc);
        n_cmp++;
        if (cyc != 256) begin
            n_err++;
            $display("FAIL abort_reclear: got %0d cycles want 256", cyc);
        end
        run_dump(1'b0, -1, "post_abort");
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_border();
        test_stall();
        test_clear_drop_and_reset();
        test_full_frame();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
